// File: rtl/ram8_fifo_ctrl.sv
// ram8_fifo_ctrl: 9-byte FIFO built from an external RAM8 plus a registered head stage.
// Optional RAM8_FIFO_FLUSH_EN adds a synchronous flush input.
module ram8_fifo_ctrl #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
`ifdef RAM8_FIFO_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [DATA_W-1:0] push_data,
    output logic              pop_valid,
    input  logic              pop_ready,
    output logic [DATA_W-1:0] pop_data,
    output logic [ADDR_W:0]   level,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_do
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   ram_cnt;
    logic              fl, run, head_free, prefetch, bypass, push_fire, rd, wr;

`ifdef RAM8_FIFO_FLUSH_EN
    assign fl = flush;
`else
    assign fl = 1'b0;
`endif

    always_comb begin
        run        = !RST && !fl;
        head_free  = !pop_valid || pop_ready;
        prefetch   = head_free && (ram_cnt != '0);
        bypass     = head_free && (ram_cnt == '0);
        push_ready = run && (ram_cnt != DEPTH) && !prefetch;
        push_fire  = push_valid && push_ready;
        rd         = run && prefetch;
        wr         = push_fire && !bypass;
        ram_en     = rd || wr;
        ram_we     = wr;
        ram_a      = rd ? rd_ptr : wr ? wr_ptr : '0;
        ram_di     = wr ? push_data : '0;
        level      = ram_cnt + {{ADDR_W{1'b0}}, pop_valid};
    end

    // The RAM port serves either a head refill or a push write, refill first.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            pop_valid <= 1'b0;
            pop_data  <= '0;
        end else if (fl) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            pop_valid <= 1'b0;
        end else if (rd) begin
            pop_data  <= ram_do;
            pop_valid <= 1'b1;
            rd_ptr    <= rd_ptr + 1'b1;
            ram_cnt   <= ram_cnt - 1'b1;
        end else if (push_fire && bypass) begin
            pop_data  <= push_data;
            pop_valid <= 1'b1;
        end else if (wr) begin
            wr_ptr    <= wr_ptr + 1'b1;
            ram_cnt   <= ram_cnt + 1'b1;
        end else if (pop_valid && pop_ready) begin
            pop_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ram8_fifo_ctrl.sv
// tb_ram8_fifo_ctrl: directed scoreboard bench for ram8_fifo_ctrl with a behavioural RAM8.
module tb_ram8_fifo_ctrl;
    logic       CLK = 1'b0;
    logic       RST, push_valid, push_ready, pop_valid, pop_ready;
    logic [7:0] push_data, pop_data, ram_di, ram_do;
    logic [3:0] level;
    logic       ram_en, ram_we;
    logic [2:0] ram_a;
    logic [7:0] mem [8];
    logic [7:0] q [$];
    logic       acc;
    int         vecs = 0, errs = 0;
`ifdef RAM8_FIFO_FLUSH_EN
    logic       flush = 1'b0;
`endif

    always #5 CLK = ~CLK;

    ram8_fifo_ctrl dut (
        .CLK(CLK), .RST(RST),
`ifdef RAM8_FIFO_FLUSH_EN
        .flush(flush),
`endif
        .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
        .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
        .level(level), .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a),
        .ram_di(ram_di), .ram_do(ram_do)
    );

    assign ram_do = mem[ram_a];
    always @(posedge CLK) if (ram_en && ram_we) mem[ram_a] <= ram_di;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observe the settled cycle at the falling edge; pops are scored before the same-cycle push.
    task automatic sample();
        @(negedge CLK);
        acc = 1'b0;
        if (RST) begin
            chk("rst_push_ready", push_ready, 0);
            chk("rst_ram_en", ram_en, 0);
        end else begin
            if (pop_valid && pop_ready) begin
                chk("pop_avail", q.size() != 0, 1);
                if (q.size() != 0) chk("pop_data", pop_data, q.pop_front());
            end
            if (push_valid && push_ready) begin
                q.push_back(push_data);
                acc = 1'b1;
            end
        end
    endtask

    task automatic adv();
        @(posedge CLK);
        #1;
    endtask

    task automatic step();
        sample();
        adv();
    endtask

    initial begin
        logic [7:0] d;
        int n;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        RST = 1'b1; push_valid = 1'b0; pop_ready = 1'b0; push_data = 8'h00;
        step(); step();
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("idle_pop_valid", pop_valid, 0);
            chk("idle_level", level, 0);
            chk("idle_push_ready", push_ready, 1);
            chk("idle_ram_en", ram_en, 0);
            adv();
        end
        push_valid = 1'b1; push_data = 8'hA5;
        sample();
        chk("bypass_ram_en", ram_en, 0);
        adv();
        push_valid = 1'b0;
        sample();
        chk("bypass_pop_valid", pop_valid, 1);
        chk("bypass_pop_data", pop_data, 8'hA5);
        chk("bypass_level", level, 1);
        adv();
        pop_ready = 1'b1;
        step();
        pop_ready = 1'b0;
        sample();
        chk("drained_pop_valid", pop_valid, 0);
        chk("drained_level", level, 0);
        adv();
        for (int i = 1; i <= 9; i++) begin
            push_valid = 1'b1; push_data = 8'(i);
            sample();
            chk("fill_push_ready", push_ready, 1);
            if (i == 1) chk("fill_bypass_en", ram_en, 0);
            else begin
                chk("fill_we", {ram_en, ram_we}, 2'b11);
                chk("fill_addr", ram_a, i - 2);
                chk("fill_di", ram_di, i);
            end
            adv();
        end
        push_data = 8'hAA;
        sample();
        chk("full_push_ready", push_ready, 0);
        chk("full_level", level, 9);
        chk("full_head", pop_data, 8'h01);
        adv();
        push_valid = 1'b0; pop_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            sample();
            if (k < 8) begin
                chk("drain_rd", {ram_en, ram_we}, 2'b10);
                chk("drain_addr", ram_a, k);
            end else chk("drain_last_en", ram_en, 0);
            adv();
        end
        pop_ready = 1'b0;
        sample();
        chk("empty_pop_valid", pop_valid, 0);
        chk("empty_level", level, 0);
        chk("empty_queue", q.size(), 0);
        adv();
        d = 8'h40;
        for (int i = 0; i < 4; i++) begin
            push_valid = 1'b1; push_data = d;
            step();
            d++;
        end
        pop_ready = 1'b1; push_data = d;
        sample();
        chk("prefetch_stall", push_ready, 0);
        chk("prefetch_level", level, 4);
        adv();
        for (int c = 0; c < 80; c++) begin
            sample();
            if (acc) d++;
            adv();
            push_data = d;
            push_valid = c < 60 ? 1'($urandom_range(0, 1)) | (c < 8) : 1'b0;
            pop_ready = c < 8 ? 1'b1 : 1'($urandom_range(0, 1));
        end
        push_valid = 1'b0; pop_ready = 1'b1; n = 0;
        while ((pop_valid || q.size() != 0) && n < 40) begin
            step();
            n++;
        end
        chk("stream_drain_bound", n < 40, 1);
        chk("stream_queue_empty", q.size(), 0);
        chk("stream_bytes", d > 8'h54, 1);
        pop_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_valid = 1'b1; push_data = 8'(8'h60 + i);
            step();
        end
        push_valid = 1'b0;
        sample();
        chk("pre_rst_level", level, 5);
        adv();
        RST = 1'b1;
        step();
        RST = 1'b0;
        q.delete();
        sample();
        chk("post_rst_level", level, 0);
        chk("post_rst_pop_valid", pop_valid, 0);
        adv();
        push_valid = 1'b1; push_data = 8'h3C;
        sample();
        chk("rst_bypass_en", ram_en, 0);
        adv();
        push_valid = 1'b0; pop_ready = 1'b1;
        sample();
        chk("rst_bypass_data", pop_data, 8'h3C);
        adv();
        pop_ready = 1'b0;
`ifdef RAM8_FIFO_FLUSH_EN
        for (int i = 0; i < 5; i++) begin
            push_valid = 1'b1; push_data = 8'(8'h70 + i);
            step();
        end
        push_valid = 1'b1; pop_ready = 1'b1; flush = 1'b1;
        @(negedge CLK);
        chk("flush_ram_en", ram_en, 0);
        chk("flush_push_ready", push_ready, 0);
        adv();
        flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
        q.delete();
        sample();
        chk("post_flush_level", level, 0);
        chk("post_flush_pop_valid", pop_valid, 0);
        adv();
        push_valid = 1'b1; push_data = 8'h3C;
        step();
        push_valid = 1'b0; pop_ready = 1'b1;
        sample();
        chk("flush_bypass_data", pop_data, 8'h3C);
        adv();
        pop_ready = 1'b0;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
